// File: rtl/div_pkg.sv
// Shared definitions for the sequential 16-by-8 restoring divider:
// operand width, step-counter width, the exception quotient and FSM states.
package div_pkg;

  localparam int DIV_W = 8;
  localparam int CNT_W = $clog2(DIV_W);

  localparam logic [DIV_W-1:0] QUOT_ALL_ONES = {DIV_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/unsigned_div_step.sv
// One combinational restoring-division step: shift {remainder, quotient}
// left by one, try subtracting the divisor, keep the difference when it
// does not go negative and record the outcome in the quotient LSB.
module unsigned_div_step
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W:0]   i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_divisor,
  output logic [W:0]   o_rem,
  output logic [W-1:0] o_quo
);

  logic [W+1:0] w_shiftRem;
  logic [W+1:0] w_diff;
  logic         w_fits;
  logic         w_unusedBits;

  // The remainder always stays below the divisor, so after a successful
  // subtraction the top bit of the difference is zero and can be dropped.
  always_comb begin
    w_shiftRem   = {i_rem, i_quo[W-1]};
    w_fits       = (w_shiftRem >= {2'b00, i_divisor});
    w_diff       = w_shiftRem - {2'b00, i_divisor};
    w_unusedBits = w_diff[W+1];
    if (w_fits) begin
      o_rem = w_diff[W:0];
      o_quo = {i_quo[W-2:0], 1'b1};
    end else begin
      o_rem = w_shiftRem[W:0];
      o_quo = {i_quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/unsigned_seq_divider_16by8.sv
// Sequential unsigned divider, 2W-bit dividend by W-bit divisor, one
// quotient bit per clock, valid/ready handshake with one operation in flight.
// Results are copied into an output register in the first DONE cycle, so
// out_valid rises one clock after the FSM enters DONE.
module unsigned_seq_divider_16by8
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*DIV_W-1:0]   dividend,
  input  logic [DIV_W-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIV_W-1:0]     quotient,
  output logic [DIV_W-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int W = DIV_W;

  state_t r_state;
  state_t w_nextState;

  logic [W:0]       r_rem;
  logic [W-1:0]     r_quo;
  logic [W-1:0]     r_divisor;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dbz;
  logic             r_ovf;

  logic [W-1:0]     r_quotient;
  logic [W-1:0]     r_remainder;
  logic             r_divByZero;
  logic             r_overflow;
  logic             r_outValid;

  logic [W:0]       w_stepRem;
  logic [W-1:0]     w_stepQuo;
  logic             w_inReady;
  logic             w_accept;
  logic             w_running;
  logic             w_capture;
  logic             w_handshake;
  logic             w_isZero;
  logic             w_isOvf;
  logic             w_lastStep;

  unsigned_div_step #(.W(W)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_stepRem),
    .o_quo     (w_stepQuo)
  );

  // Exception detection on the incoming request; divide-by-zero wins.
  always_comb begin
    w_isZero   = (divisor == '0);
    w_isOvf    = (dividend[2*W-1:W] >= divisor);
    w_lastStep = (r_cnt == CNT_W'(W-1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: exceptions skip RUN, normal requests take W steps.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_nextState = (w_isZero || w_isOvf) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_lastStep) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (w_handshake) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // FSM-decoded control strobes.
  always_comb begin
    w_inReady   = (r_state == IDLE);
    w_accept    = w_inReady && in_valid;
    w_running   = (r_state == RUN);
    w_capture   = (r_state == DONE) && !r_outValid;
    w_handshake = r_outValid && out_ready;
  end

  // Working registers: operand capture on accept, one restoring step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_dbz     <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_divisor <= divisor;
      r_cnt     <= '0;
      if (w_isZero) begin
        r_dbz <= 1'b1;
        r_ovf <= 1'b0;
        r_quo <= QUOT_ALL_ONES;
        r_rem <= '0;
      end else if (w_isOvf) begin
        r_dbz <= 1'b0;
        r_ovf <= 1'b1;
        r_quo <= QUOT_ALL_ONES;
        r_rem <= '0;
      end else begin
        r_dbz <= 1'b0;
        r_ovf <= 1'b0;
        r_quo <= dividend[W-1:0];
        r_rem <= {1'b0, dividend[2*W-1:W]};
      end
    end else if (w_running) begin
      r_rem <= w_stepRem;
      r_quo <= w_stepQuo;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Output register: loaded once in DONE and held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divByZero <= 1'b0;
      r_overflow  <= 1'b0;
      r_outValid  <= 1'b0;
    end else if (w_capture) begin
      r_quotient  <= r_quo;
      r_remainder <= r_rem[W-1:0];
      r_divByZero <= r_dbz;
      r_overflow  <= r_ovf;
      r_outValid  <= 1'b1;
    end else if (w_handshake) begin
      r_outValid  <= 1'b0;
    end
  end

  assign in_ready    = w_inReady;
  assign out_valid   = r_outValid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_divByZero;
  assign overflow    = r_overflow;

endmodule
